mux_uart_rx: RTL and testbench

MUX_UART_RX -- requirements
Module: mux_uart_rx

---
 rtl/mux_pkg.sv | 32 +++
 rtl/mux_rx_fifo.sv | 121 ++++++++++++
 rtl/mux_uart_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_mux_uart_rx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and constants for the multiplexer UART receiver.
//               It holds the receive FSM state encoding, the FIFO entry
//               layout, and the baud/divider constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Divider for 9600 baud from a 27 MHz bit clock
    localparam int DIV_9600    = 2812;
    // Smallest divider the bit timing is designed for
    localparam int MIN_DIVIDER = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_entry_t;

endpackage
`default_nettype wire

// File: rtl/mux_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mux_rx_fifo
// Description : Receive storage for mux_uart_rx. When DEPTH == 1 it is a
//               single holding register. Otherwise it is a ring buffer whose
//               pointers carry an extra wrap bit, which separates the full
//               case from the empty case. A push into full storage is
//               dropped and sets the sticky overrun flag. A push that
//               coincides with a pop always succeeds.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               i_push           - write i_push_entry this cycle
//               i_push_entry     - {data, perr, ferr} to store
//               i_pop            - consumer ready; pops only when o_valid
//               i_clr_overrun    - clear sticky overrun (a new drop wins)
//               o_head           - head entry, zero while empty
//               o_valid          - storage non-empty
//               o_overrun        - sticky overrun flag
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rx_fifo
    import mux_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  rx_entry_t i_push_entry,
    input  logic      i_pop,
    input  logic      i_clr_overrun,
    output rx_entry_t o_head,
    output logic      o_valid,
    output logic      o_overrun
);

    logic w_full;
    logic w_pop;
    logic w_drop;
    logic w_wr;
    logic r_overrun;

    assign w_pop  = o_valid & i_pop;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_drop = i_push & w_full & ~w_pop;
    assign w_wr   = i_push & ~w_drop;

    generate
        if (DEPTH == 1) begin : g_hold
            logic      r_full;
            rx_entry_t r_hold;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_full <= 1'b0;
                    r_hold <= '0;
                end else begin
                    if (w_wr) begin
                        r_full <= 1'b1;
                        r_hold <= i_push_entry;
                    end else if (w_pop) begin
                        r_full <= 1'b0;
                    end
                end
            end

            assign w_full  = r_full;
            assign o_valid = r_full;
            assign o_head  = r_full ? r_hold : '0;
        end else begin : g_ring
            localparam int c_AW = $clog2(DEPTH);

            rx_entry_t       r_mem [DEPTH];
            logic [c_AW:0]   r_wr_ptr;
            logic [c_AW:0]   r_rd_ptr;
            logic            w_empty;

            assign w_empty = (r_wr_ptr == r_rd_ptr);
            assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                             (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_wr) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
            end

            // Storage needs no reset; the head is gated off while empty
            always_ff @(posedge clk) begin
                if (w_wr) begin
                    r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_entry;
                end
            end

            assign o_valid = ~w_empty;
            assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
        end
    endgenerate

    // A drop in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/mux_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : mux_uart_rx
// Description : UART receiver. The frame format (5..8 data bits, optional
//               even/odd parity) and the divider are latched at each start
//               bit. Each received frame is pushed as {data, perr, ferr}
//               into mux_rx_fifo. A held-low line (break) is pushed once,
//               and the FSM then waits in BREAK_WAIT for the line to go
//               high.
// Build macro : MUX_RX_FIFO_EN - defined: FIFO of FIFO_DEPTH entries;
//               undefined: a single holding register (FIFO_DEPTH ignored).
// Ports       : bit_clock, reset  - clock, asynchronous active-high reset
//               uart_rx           - serial line, idles high
//               divider           - bit_clock cycles per bit (>= 16)
//               data_len          - data bits = 5 + data_len
//               parity_enabled    - parity bit present
//               parity            - 1 = even, 0 = odd
//               rx_ready          - pop the head entry
//               clr_overrun       - clear sticky overrun
//               rx_data           - head byte, right-justified
//               rx_valid          - receive storage non-empty
//               parity_err        - head entry parity error
//               framing_err       - head entry stop bit was 0
//               overrun           - sticky, a byte was dropped
//               busy              - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mux_uart_rx
    import mux_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        bit_clock,
    input  logic        reset,
    input  logic        uart_rx,
    input  logic [15:0] divider,
    input  logic [1:0]  data_len,
    input  logic        parity_enabled,
    input  logic        parity,
    input  logic        rx_ready,
    input  logic        clr_overrun,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        framing_err,
    output logic        overrun,
    output logic        busy
);

`ifdef MUX_RX_FIFO_EN
    localparam int c_DEPTH = FIFO_DEPTH;
`else
    // Storage collapses to a single holding register
    localparam int c_DEPTH = 1 + 0 * FIFO_DEPTH;
`endif

    // Synchronizer and edge detection
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [1:0]  r_flush;
    logic        w_rx;
    logic        w_fall;

    // Frame state
    rx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_div;
    logic [1:0]  r_len;
    logic        r_par_en;
    logic        r_par;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit;
    logic        r_perr;
    logic        r_busy;

    logic        w_half;
    logic        w_sample;
    logic        w_last_bit;
    logic        w_push;
    rx_entry_t   w_push_entry;
    rx_entry_t   w_head;

    always_ff @(posedge bit_clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_flush <= 2'd0;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_flush != 2'd3) begin
                r_flush <= r_flush + 2'd1;
            end
        end
    end

    assign w_rx = r_sync2;
    // Edge detection is ignored until the preset ones have left the
    // synchronizer. Otherwise a line that is already low at reset release
    // would look like a start bit.
    assign w_fall = (r_flush == 2'd3) & r_prev & ~r_sync2;

    assign w_half     = (r_cnt == {1'b0, r_div[15:1]});
    assign w_sample   = (r_cnt == r_div);
    assign w_last_bit = (r_bit == (3'd4 + {1'b0, r_len}));

    assign w_push       = (r_state == STOP) & w_sample;
    assign w_push_entry = '{data: r_shift, perr: r_perr, ferr: ~w_rx};

    // The counter restarts at 1 on each sample. The sample cycle itself is
    // the first cycle of the next bit period, so bit centres stay exactly
    // divider cycles apart.
    always_ff @(posedge bit_clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_div    <= '0;
            r_len    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_perr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state  <= START;
                        r_cnt    <= '0;
                        r_bit    <= '0;
                        r_shift  <= '0;
                        r_perr   <= 1'b0;
                        r_div    <= divider;
                        r_len    <= data_len;
                        r_par_en <= parity_enabled;
                        r_par    <= parity;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (w_half) begin
                        if (!w_rx) begin
                            r_state <= DATA;
                            r_cnt   <= 16'd1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_shift[r_bit] <= w_rx;
                        r_cnt          <= 16'd1;
                        if (w_last_bit) begin
                            r_state <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        // Unused upper shift bits are zero and do not
                        // affect the reduction
                        r_perr  <= ((^r_shift) ^ w_rx) != ~r_par;
                        r_cnt   <= 16'd1;
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        r_cnt   <= '0;
                        r_state <= w_rx ? IDLE : BREAK_WAIT;
                        r_busy  <= ~w_rx;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                BREAK_WAIT: begin
                    if (w_rx) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    mux_rx_fifo #(
        .DEPTH         (c_DEPTH)
    ) u_fifo (
        .clk           (bit_clock),
        .rst           (reset),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_pop         (rx_ready),
        .i_clr_overrun (clr_overrun),
        .o_head        (w_head),
        .o_valid       (rx_valid),
        .o_overrun     (overrun)
    );

    assign rx_data     = w_head.data;
    assign parity_err  = w_head.perr;
    assign framing_err = w_head.ferr;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_uart_rx
// Description : Directed testbench for mux_uart_rx. Frames are built
//               bit by bit, and all expected entries are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_uart_rx;

    localparam int DIV = 16;
`ifdef MUX_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        bit_clock = 1'b0;
    logic        reset;
    logic        uart_rx;
    logic [15:0] divider;
    logic [1:0]  data_len;
    logic        parity_enabled;
    logic        parity;
    logic        rx_ready;
    logic        clr_overrun;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        framing_err;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int v_push   = -1;

    mux_uart_rx #(
        .FIFO_DEPTH     (4)
    ) dut (
        .bit_clock      (bit_clock),
        .reset          (reset),
        .uart_rx        (uart_rx),
        .divider        (divider),
        .data_len       (data_len),
        .parity_enabled (parity_enabled),
        .parity         (parity),
        .rx_ready       (rx_ready),
        .clr_overrun    (clr_overrun),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_err     (parity_err),
        .framing_err    (framing_err),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 bit_clock = ~bit_clock;

    task automatic tick();
        @(posedge bit_clock);
        #1;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
    endtask

    // Send one frame using the current configuration inputs. rx_ready pulses
    // for the single cycle index pop_at. first_valid returns the first cycle
    // index after which rx_valid reads 1.
    task automatic send_frame(input logic [7:0] d, input bit inv_par, input bit stop_bit,
                              input int pop_at, output int first_valid);
        logic [15:0] fb;
        int          nb;
        int          nd;
        logic        p;
        nd = 5 + int'(data_len);
        fb = '1;
        nb = 0;
        fb[nb] = 1'b0;
        nb++;
        p = 1'b0;
        for (int i = 0; i < nd; i++) begin
            fb[nb] = d[i];
            p      = p ^ d[i];
            nb++;
        end
        if (parity_enabled) begin
            fb[nb] = (parity ? p : ~p) ^ inv_par;
            nb++;
        end
        fb[nb] = stop_bit;
        nb     = nb + 3;
        first_valid = -1;
        for (int c = 0; c < nb * DIV; c++) begin
            uart_rx  = fb[c / DIV];
            rx_ready = (c == pop_at);
            tick();
            if (first_valid < 0 && rx_valid) first_valid = c;
        end
        rx_ready = 1'b0;
        uart_rx  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks += 6;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_framing_err: got %b want 0", framing_err); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_parity();
        int fv;
        send_frame(8'h41, 1'b0, 1'b1, -1, fv);
        n_checks += 5;
        if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL par_ok_valid: got %b want 1", rx_valid); end
        if (rx_data !== 8'h41) begin n_fail++; $display("FAIL par_ok_data: got %h want 41", rx_data); end
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_ok_perr: got %b want 0", parity_err); end
        if (framing_err !== 1'b0) begin n_fail++; $display("FAIL par_ok_ferr: got %b want 0", framing_err); end
        pop_one();
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL par_ok_popped: got %b want 0", rx_valid); end

        send_frame(8'h41, 1'b1, 1'b1, -1, fv);
        n_checks += 3;
        if (rx_data !== 8'h41) begin n_fail++; $display("FAIL par_bad_data: got %h want 41", rx_data); end
        if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr: got %b want 1", parity_err); end
        if (framing_err !== 1'b0) begin n_fail++; $display("FAIL par_bad_ferr: got %b want 0", framing_err); end
        pop_one();
    endtask

    task automatic test_formats();
        int fv;
        // 8 data bits, no parity
        data_len = 2'd3; parity_enabled = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, -1, fv);
        n_checks += 2;
        if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL fmt8n_data: got %h want a5", rx_data); end
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL fmt8n_perr: got %b want 0", parity_err); end
        pop_one();
        // 5 data bits, odd parity; upper bits of rx_data must read zero
        data_len = 2'd0; parity_enabled = 1'b1; parity = 1'b0;
        send_frame(8'h15, 1'b0, 1'b1, -1, fv);
        n_checks += 2;
        if (rx_data !== 8'h15) begin n_fail++; $display("FAIL fmt5o_data: got %h want 15", rx_data); end
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL fmt5o_perr: got %b want 0", parity_err); end
        pop_one();
        data_len = 2'd2; parity = 1'b1;
    endtask

    task automatic test_false_start();
        int k;
        uart_rx = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy: got %b want 1", busy); end
        uart_rx = 1'b1;
        k = 0;
        while (busy === 1'b1 && k < 8) begin
            tick();
            k++;
        end
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: busy %b after %0d cycles want 0", busy, k); end
        repeat (32) tick();
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL false_start_push: rx_valid %b want 0", rx_valid); end
    endtask

    task automatic test_break();
        uart_rx = 1'b0;
        repeat (20 * DIV) tick();
        n_checks += 5;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL break_wait_busy: got %b want 1", busy); end
        if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL break_valid: got %b want 1", rx_valid); end
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL break_data: got %h want 00", rx_data); end
        if (framing_err !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b want 1", framing_err); end
        uart_rx = 1'b1;
        repeat (4) tick();
        if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release: busy %b want 0", busy); end
        pop_one();
        repeat (64) tick();
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL break_single: rx_valid %b want 0", rx_valid); end
    endtask

    task automatic test_overrun();
        int fv;
        do_reset();
        rx_ready = 1'b0;
        send_frame(8'h01, 1'b0, 1'b1, -1, v_push);
        n_checks++;
        if (v_push < 0) begin n_fail++; $display("FAIL ovr_first_push: rx_valid never rose, got %0d want >=0", v_push); end
        for (int b = 2; b <= 5; b++) send_frame(8'(b), 1'b0, 1'b1, -1, fv);
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        for (int i = 1; i <= DEPTH; i++) begin
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
                n_fail++; $display("FAIL ovr_entry%0d: valid %b data %h want 1 %h", i, rx_valid, rx_data, 8'(i));
            end
            pop_one();
        end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained: got %b want 0", rx_valid); end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    endtask

    task automatic test_full_pop();
        int fv;
        do_reset();
        for (int b = 1; b <= DEPTH; b++) send_frame(8'(b), 1'b0, 1'b1, -1, fv);
        // Pop exactly on the push cycle of the next frame
        send_frame(8'(DEPTH + 1), 1'b0, 1'b1, v_push, fv);
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop_overrun: got %b want 0", overrun); end
        for (int i = 2; i <= DEPTH + 1; i++) begin
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
                n_fail++; $display("FAIL fullpop_entry%0d: valid %b data %h want 1 %h", i, rx_valid, rx_data, 8'(i));
            end
            pop_one();
        end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_drained: got %b want 0", rx_valid); end
    endtask

    task automatic test_reset_mid();
        int fv;
        send_frame(8'h11, 1'b0, 1'b1, -1, fv);
        uart_rx = 1'b0;
        repeat (40) tick();
        #2 reset = 1'b1;
        #1;
        n_checks += 3;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        repeat (2) tick();
        reset = 1'b0;
        // Line still low after release: not a fresh start bit
        repeat (20) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_restart: busy %b want 0", busy); end
        uart_rx = 1'b1;
        repeat (32) tick();
        send_frame(8'h5A, 1'b0, 1'b1, -1, fv);
        n_checks += 4;
        if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid: got %b want 1", rx_valid); end
        if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rstmid_next_data: got %h want 5a", rx_data); end
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_perr: got %b want 0", parity_err); end
        if (framing_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_ferr: got %b want 0", framing_err); end
        pop_one();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        uart_rx        = 1'b1;
        divider        = 16'(DIV);
        data_len       = 2'd2;
        parity_enabled = 1'b1;
        parity         = 1'b1;
        rx_ready       = 1'b0;
        clr_overrun    = 1'b0;
        test_reset();
        test_parity();
        test_formats();
        test_false_start();
        test_break();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
